// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) beats a FIFO-buffered multi-cycle unit (B).
// Optional macro REGWB_PENDING_EN adds the o_pending in-flight register scoreboard output.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_a_valid,
    input  logic [ADDR_W-1:0]                 i_a_addr,
    input  logic [DATA_W-1:0]                 i_a_data,
    input  logic                              i_b_valid,
    output logic                              o_b_ready,
    input  logic [ADDR_W-1:0]                 i_b_addr,
    input  logic [DATA_W-1:0]                 i_b_data,
    output logic [ADDR_W-1:0]                 o_wa,
    output logic [DATA_W-1:0]                 o_wd,
    output logic                              o_we,
`ifdef REGWB_PENDING_EN
    output logic [2**ADDR_W-1:0]              o_pending,
`endif
    output logic [$clog2(FIFO_DEPTH):0]       o_fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]     r_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_kill;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_wa;
    logic [DATA_W-1:0]     r_wd;

    logic w_a_wr;
    logic w_b_ready;
    logic w_push;
    logic w_pop;
    logic w_head_kill;
    logic w_push_killed;

    assign w_a_wr        = i_a_valid && (i_a_addr != '0);
    assign w_b_ready     = !i_rst && (r_count < CNT_W'(FIFO_DEPTH));
    // r0 pushes complete the handshake but never occupy a slot
    assign w_push        = i_b_valid && w_b_ready && (i_b_addr != '0);
    assign w_pop         = !w_a_wr && (r_count != '0);
    assign w_head_kill   = r_kill[r_rd_ptr];
    assign w_push_killed = w_a_wr && (i_b_addr == i_a_addr);

    assign o_b_ready    = w_b_ready;
    assign o_fifo_count = r_count;
    assign o_we         = r_we;
    assign o_wa         = r_wa;
    assign o_wd         = r_wd;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_b_addr;
            r_data[r_wr_ptr] <= i_b_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_kill   <= '0;
        end else begin
            if (w_a_wr) begin
                r_we <= 1'b1;
                r_wa <= i_a_addr;
                r_wd <= i_a_data;
            end else if (w_pop) begin
                r_we <= !w_head_kill;
                if (!w_head_kill) begin
                    r_wa <= r_addr[r_rd_ptr];
                    r_wd <= r_data[r_rd_ptr];
                end
            end else begin
                r_we <= 1'b0;
            end

            // stale slots may get marked too; a push always rewrites its own flag
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_a_wr && (r_addr[i] == i_a_addr)) begin
                    r_kill[i] <= 1'b1;
                end
            end

            if (w_push) begin
                r_kill[r_wr_ptr] <= w_push_killed;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

`ifdef REGWB_PENDING_EN
    logic [2**ADDR_W-1:0] w_pending;
    logic [PTR_W-1:0]     w_off;

    always_comb begin
        w_pending = '0;
        w_off     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) && !r_kill[i]) begin
                w_pending[r_addr[i]] = 1'b1;
            end
        end
        if (r_we) begin
            w_pending[r_wa] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    assign o_pending = w_pending;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps then random traffic against a queue model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  fifo_count;
`ifdef REGWB_PENDING_EN
    logic [31:0] pending;
`endif

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_a_valid    (a_valid),
        .i_a_addr     (a_addr),
        .i_a_data     (a_data),
        .i_b_valid    (b_valid),
        .o_b_ready    (b_ready),
        .i_b_addr     (b_addr),
        .i_b_data     (b_data),
        .o_wa         (wa),
        .o_wd         (wd),
        .o_we         (we),
`ifdef REGWB_PENDING_EN
        .o_pending    (pending),
`endif
        .o_fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t        q[$];
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    int          total;
    int          bad;
    int          r7_writes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check ready, advance the model, check registered outputs.
    task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit bv, input logic [4:0] ba, input logic [31:0] bd);
        bit          a_wr;
        bit          rdy;
        bit          push;
        ent_t        e;
        logic [31:0] epend;
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        rdy = !r && (q.size() < DEPTH);
        chk("b_ready", 64'(b_ready), 64'(rdy));
        a_wr = av && (aa != 0);
        push = bv && rdy && (ba != 0);
        if (r) begin
            q.delete();
            ewe = 0; ewa = 0; ewd = 0;
        end else begin
            if (a_wr) begin
                foreach (q[k]) if (q[k].addr == aa) q[k].killed = 1;
                ewe = 1; ewa = aa; ewd = ad;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                ewe = !e.killed;
                if (!e.killed) begin
                    ewa = e.addr; ewd = e.data;
                end
            end else begin
                ewe = 0;
            end
            if (push) begin
                e.addr = ba; e.data = bd; e.killed = a_wr && (ba == aa);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("we", 64'(we), 64'(ewe));
        chk("wa", 64'(wa), 64'(ewa));
        chk("wd", 64'(wd), 64'(ewd));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        if (we && wa == 5'd7) r7_writes++;
        epend = '0;
        foreach (q[k]) if (!q[k].killed) epend[q[k].addr] = 1'b1;
        if (ewe) epend[ewa] = 1'b1;
        epend[0] = 1'b0;
`ifdef REGWB_PENDING_EN
        chk("pending", 64'(pending), 64'(epend));
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        total = 0; bad = 0; r7_writes = 0;
        ewe = 0; ewa = 0; ewd = 0;

        // reset held two cycles with b_valid asserted
        step(1, 0, 0, 0, 1, 5'd9, 32'h99);
        step(1, 0, 0, 0, 1, 5'd9, 32'h99);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_wa", 64'(wa), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);

        // plain A write then idle
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("a_we", 64'(we), 64'd1);
        chk("a_wd", 64'(wd), 64'hDEADBEEF);
        idle();
        chk("a_we_drop", 64'(we), 64'd0);

        // r0 on both ports
        step(0, 1, 5'd0, 32'h1234, 0, 0, 0);
        chk("r0_a_we", 64'(we), 64'd0);
        step(0, 0, 0, 0, 1, 5'd0, 32'h55);
        chk("r0_b_count", 64'(fifo_count), 64'd0);
        idle();
        chk("r0_b_we", 64'(we), 64'd0);

        // fill while A busy, then drain in order
        for (int i = 1; i <= 4; i++) step(0, 1, 5'd10, 32'h1000 + i, 1, 5'(i), 32'h100 + i);
        chk("full_count", 64'(fifo_count), 64'd4);
        step(0, 1, 5'd10, 32'h2000, 1, 5'd6, 32'h666);
        chk("full_ready", 64'(b_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("drain_wa", 64'(wa), 64'(i));
            chk("drain_wd", 64'(wd), 64'(32'h100 + i));
        end
        idle();

        // older queued B write to r7 killed by younger A write
        r7_writes = 0;
        step(0, 1, 5'd10, 32'h1, 1, 5'd7, 32'h11);
        step(0, 1, 5'd7, 32'h22, 0, 0, 0);
        chk("kill_wd", 64'(wd), 64'h22);
        idle();
        chk("kill_pop_we", 64'(we), 64'd0);
        chk("kill_count", 64'(fifo_count), 64'd0);
        idle();
        chk("kill_r7_once", 64'(r7_writes), 64'd1);

        // same-edge kill
        step(0, 1, 5'd3, 32'hBB, 1, 5'd3, 32'hAA);
        chk("same_wa", 64'(wa), 64'd3);
        chk("same_wd", 64'(wd), 64'hBB);
        idle();
        chk("same_pop_we", 64'(we), 64'd0);
        idle();

        // random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
        end
        for (int n = 0; n < 6; n++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
